// File: rtl/instr_fetch_buffer.sv
// Instruction fetch unit: issues in-order word fetches, buffers returned
// instructions with their PCs for decode, and restarts on PC redirect while
// discarding responses to requests that were in flight at the redirect.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  fetch_entry_t fifo_q [DEPTH];
  fetch_entry_t fifo_d [DEPTH];

  logic [SW-1:0] live;
  logic [CW-1:0] wr_idx;
  logic          fire;
  logic          pop;
  logic          push;
  logic [31:0]   target;

  // Head of the shift FIFO drives decode; it keeps its last contents when empty.
  assign out_valid = (count_q != '0);
  assign out_instr = fifo_q[0].instr;
  assign out_pc    = fifo_q[0].pc;
  assign req_addr  = fetch_pc_q;

  // Credit-based issue, response accounting, FIFO update and redirect handling.
  always_comb begin
    live          = SW'(count_q) + SW'(outstanding_q) - SW'(drop_cnt_q);
    target        = redirect_addr & ~32'h3;
    req_valid     = reset & ~redirect_valid & (live < SW'(DEPTH))
                    & (outstanding_q < OW'(MAX_OUT));
    fire          = req_valid & req_ready;
    pop           = out_valid & out_ready;
    push          = resp_valid & (drop_cnt_q == '0) & ~redirect_valid;
    wr_idx        = count_q - CW'(pop);

    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + OW'(fire) - OW'(resp_valid);
    drop_cnt_d    = drop_cnt_q;
    fifo_d        = fifo_q;

    if (fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = target;
      resp_pc_d  = target;
      count_d    = '0;
      drop_cnt_d = outstanding_d;
    end else begin
      if (resp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - OW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (pop && ((i + 32'd1) < 32'(count_q))) begin
          fifo_d[i] = fifo_q[i + 1];
        end
        if (push && (32'(wr_idx) == i)) begin
          fifo_d[i] = '{instr: resp_data, pc: resp_pc_q};
        end
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_q        <= fifo_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: memory model plus queue-based reference of the
// fetch stream, redirect table, directed corner sequences and random traffic.
module tb_instr_fetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  instr_fetch_buffer #(
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // In-flight request: address actually sent, PC the model expects, stale flag.
  typedef struct {
    logic [31:0] req;
    logic [31:0] pc;
    bit          stale;
  } infl_t;

  typedef struct {
    logic [31:0] rda;
    logic [31:0] exp_a;
    logic [31:0] exp_n;
  } vec_t;

  infl_t       inflight[$];
  logic [31:0] mfifo[$];
  logic [31:0] fire_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_fetch;
  logic [31:0] last_pc;
  logic [31:0] last_instr;
  bit          model_ok = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare outputs against the reference, then advance it by this cycle's events.
  task automatic model_cycle();
    int   live;
    logic exp_rv;
    logic fire;
    logic pop;
    infl_t e;
    if (model_ok) begin
      live = 0;
      foreach (inflight[i]) if (!inflight[i].stale) live++;
      exp_rv = reset && !redirect_valid && ((mfifo.size() + live) < DEPTH)
               && (inflight.size() < MAX_OUT);
      chk("req_valid", 32'(req_valid), 32'(exp_rv));
      if (req_valid && exp_rv) chk("req_addr", req_addr, exp_fetch);
      chk("out_valid", 32'(out_valid), 32'(mfifo.size() != 0));
      if (mfifo.size() != 0) begin
        last_pc    = mfifo[0];
        last_instr = mem_word(mfifo[0]);
      end
      chk("out_pc", out_pc, last_pc);
      chk("out_instr", out_instr, last_instr);
    end else if (!reset) begin
      chk("req_valid_in_reset", 32'(req_valid), 32'd0);
    end

    fire = req_valid & req_ready;
    pop  = out_valid & out_ready;
    if (!reset) begin
      inflight.delete();
      mfifo.delete();
      exp_fetch  = RESET_PC;
      last_pc    = 32'd0;
      last_instr = 32'd0;
      model_ok   = 1;
      return;
    end
    if (!model_ok) return;
    if (pop && mfifo.size() != 0) pop_log.push_back(mfifo.pop_front());
    if (resp_valid && inflight.size() != 0) begin
      e = inflight.pop_front();
      if (!e.stale && !redirect_valid) mfifo.push_back(e.pc);
    end
    if (fire) begin
      inflight.push_back('{req: req_addr, pc: exp_fetch, stale: 1'b0});
      fire_log.push_back(req_addr);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redirect_valid) begin
      mfifo.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      exp_fetch = redirect_addr & ~32'h3;
    end
  endtask

  // One clock: drive inputs, memory answers per mode (0 none, 1 always, 2 random).
  task automatic step(input logic rdv, input logic [31:0] rda, input logic rr,
                      input logic orr, input int mode);
    redirect_valid = rdv;
    redirect_addr  = rda;
    req_ready      = rr;
    out_ready      = orr;
    resp_valid     = 1'b0;
    resp_data      = 32'($urandom);
    if (reset && inflight.size() != 0 &&
        (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1))) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(inflight[0].req);
    end
    @(negedge clock);
    model_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 32'd0, 1'b0, 1'b0, 0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 0);
    reset = 1'b1;
  endtask

  task automatic chk_q(input string name, input logic [31:0] q[$], input int idx,
                       input logic [31:0] exp);
    if (q.size() > idx) chk(name, q[idx], exp);
    else chk({name, "_missing"}, 32'(q.size()), 32'(idx + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  vec_t vt[5];

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; out_ready = 1'b0;
    vt[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vt[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[3] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
    vt[4] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};
    @(posedge clock);
    #1;
    do_reset();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);

    // Redirect target alignment table.
    foreach (vt[k]) begin
      do_reset();
      step(1'b0, 32'd0, 1'b0, 1'b1, 0);
      step(1'b1, vt[k].rda, 1'b0, 1'b1, 0);
      fire_log.delete();
      step(1'b0, 32'd0, 1'b1, 1'b1, 0);
      step(1'b0, 32'd0, 1'b1, 1'b1, 0);
      chk_q("tbl_first_addr", fire_log, 0, vt[k].exp_a);
      chk_q("tbl_next_addr", fire_log, 1, vt[k].exp_n);
    end

    // Streaming after reset with 1-cycle memory latency.
    do_reset();
    fire_log.delete(); pop_log.delete();
    repeat (8) step(1'b0, 32'd0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 4; i++) chk_q("t1_req_addr", fire_log, i, 32'(4 * i));
    for (int i = 0; i < 4; i++) chk_q("t1_out_pc", pop_log, i, 32'(4 * i));

    // Decode stalled: exactly DEPTH fires, then one fire per pop.
    do_reset();
    fire_log.delete(); pop_log.delete();
    repeat (10) step(1'b0, 32'd0, 1'b1, 1'b0, 1);
    chk("t2_fires", 32'(fire_log.size()), 32'd4);
    chk("t2_stall", 32'(req_valid), 32'd0);
    fire_log.delete();
    repeat (12) step(1'b0, 32'd0, 1'b1, 1'b1, 1);
    chk("t2_pops_enough", 32'(pop_log.size() >= 8), 32'd1);
    foreach (pop_log[i]) chk("t2_pop_seq", pop_log[i], 32'(4 * i));
    chk_q("t2_refill_addr", fire_log, 0, 32'h10);

    // Redirect with two requests in flight.
    do_reset();
    step(1'b0, 32'd0, 1'b1, 1'b1, 0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 0);
    step(1'b1, 32'h0000_0103, 1'b1, 1'b1, 0);
    fire_log.delete(); pop_log.delete();
    repeat (10) step(1'b0, 32'd0, 1'b1, 1'b1, 1);
    chk_q("t3_req_addr", fire_log, 0, 32'h100);
    chk_q("t3_out_pc", pop_log, 0, 32'h100);

    // Redirect coinciding with a response and a pop.
    do_reset();
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, 0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1);
    step(1'b1, 32'h0000_0040, 1'b1, 1'b1, 1);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    pop_log.delete();
    repeat (10) step(1'b0, 32'd0, 1'b1, 1'b1, 1);
    chk_q("t4_out_pc", pop_log, 0, 32'h40);

    // Fetch address wraps past the top of memory.
    do_reset();
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 0);
    fire_log.delete(); pop_log.delete();
    repeat (6) step(1'b0, 32'd0, 1'b1, 1'b1, 1);
    chk_q("t5_addr0", fire_log, 0, 32'hFFFF_FFF8);
    chk_q("t5_addr1", fire_log, 1, 32'hFFFF_FFFC);
    chk_q("t5_addr2", fire_log, 2, 32'h0000_0000);
    chk_q("t5_pc2", pop_log, 2, 32'h0000_0000);

    // Reset mid-operation with buffered entries and a request in flight.
    do_reset();
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0, 1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 0);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    step(1'b0, 32'd0, 1'b1, 1'b1, 0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_req_valid", 32'(req_valid), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 0);
    reset = 1'b1;
    fire_log.delete();
    step(1'b0, 32'd0, 1'b1, 1'b1, 1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 1);
    chk_q("t6_first_addr", fire_log, 0, RESET_PC);

    // Random traffic against the reference model.
    do_reset();
    repeat (1500) begin
      logic        rdv;
      logic [31:0] rda;
      rdv = ($urandom_range(0, 15) == 0);
      rda = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : 32'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      step(rdv, rda, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 2);
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
